sm_adder_table_loader: RTL

- Writer/initializer for the ROM-based sign-magnitude adder lookup table.
- Sweeps every address {a,b}, computes the 9-bit sign-magnitude sum, and writes it into the table RAM's write port.
- An optional verify pass reads every entry back through the RAM read port and checks it.
- Sits between the control logic and the table RAM that the adder later reads.

---
 rtl/sm_adder_pkg.sv | 54 +++++
 rtl/sm_adder_table_loader_if.sv | 39 +++
 rtl/sm_add_core.sv | 20 ++
 rtl/sm_adder_table_loader.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sm_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sm_adder_pkg
//  Purpose  : Shared states and sign-magnitude add function for the table loader
//  Revision : 1.0  initial release
// ============================================================================
package sm_adder_pkg;

   localparam int c_dw     = 8;
   localparam int c_mag_w  = c_dw - 1;
   localparam int c_res_w  = c_dw + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      VERIFY = 3'd2,
      VDRAIN = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Operands are zero-extended to c_dw; w is the live operand width (sign at bit w-1).
   function automatic logic [c_res_w-1:0] sm_add(input logic [c_dw-1:0] a,
                                                 input logic [c_dw-1:0] b,
                                                 input int unsigned     w);
      logic               sa;
      logic               sb;
      logic               sgn;
      logic [c_mag_w-1:0] mmask;
      logic [c_mag_w-1:0] ma;
      logic [c_mag_w-1:0] mb;
      logic [c_mag_w:0]   mag;
      mmask = ~({c_mag_w{1'b1}} << (w - 1));
      ma    = a[c_mag_w-1:0] & mmask;
      mb    = b[c_mag_w-1:0] & mmask;
      sa    = 1'(a >> (w - 1));
      sb    = 1'(b >> (w - 1));
      if (sa == sb) begin
         mag = {1'b0, ma} + {1'b0, mb};
         sgn = sa;
      end else if (ma >= mb) begin
         mag = {1'b0, ma - mb};
         sgn = sa;
      end else begin
         mag = {1'b0, mb - ma};
         sgn = sb;
      end
      if (mag == '0) begin
         sgn = 1'b0;
      end
      return c_res_w'(mag) | (c_res_w'(sgn) << w);
   endfunction

endpackage : sm_adder_pkg
`default_nettype wire

// File: rtl/sm_adder_table_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : sm_adder_table_loader_if
//  Purpose  : Control handshake plus table-RAM write/read ports of the loader
//  Revision : 1.0  initial release
// ============================================================================
interface sm_adder_table_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) ();

   logic                  start;
   logic                  verify_en;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH-1:0] err_addr;
   logic [ADDR_WIDTH-1:0] err_count;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH:0]   wr_data;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH:0]   rd_data;

   modport master (
      input  start, verify_en, rd_data,
      output busy, done, error, err_addr, err_count,
             wr_en, wr_addr, wr_data, rd_en, rd_addr
   );

   modport slave (
      output start, verify_en, rd_data,
      input  busy, done, error, err_addr, err_count,
             wr_en, wr_addr, wr_data, rd_en, rd_addr
   );

endinterface : sm_adder_table_loader_if
`default_nettype wire

// File: rtl/sm_add_core.sv
`default_nettype none
// ============================================================================
//  Module   : sm_add_core
//  Purpose  : Combinational sign-magnitude adder, {a,b} -> DATA_WIDTH+1 sum
//  Revision : 1.0  initial release
// ============================================================================
module sm_add_core
   import sm_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH:0]   o_sum
);

   assign o_sum = (DATA_WIDTH + 1)'(sm_add(c_dw'(i_a), c_dw'(i_b), DATA_WIDTH));

endmodule : sm_add_core
`default_nettype wire

// File: rtl/sm_adder_table_loader.sv
`default_nettype none
// ============================================================================
//  Module   : sm_adder_table_loader
//  Purpose  : Fills the sign-magnitude adder table RAM, optionally reads it back
//  Revision : 1.0  initial release
// ============================================================================
module sm_adder_table_loader
   import sm_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   sm_adder_table_loader_if.master  bus
);

   if (ADDR_WIDTH != 2 * DATA_WIDTH || DATA_WIDTH < 2 || DATA_WIDTH > c_dw) begin : g_cfg_check
      $error("sm_adder_table_loader: ADDR_WIDTH must be 2*DATA_WIDTH, DATA_WIDTH in 2..8");
   end

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_verify;
   logic                  r_exp_valid;
   logic [DATA_WIDTH:0]   r_exp_data;
   logic [ADDR_WIDTH-1:0] r_exp_addr;
   logic                  r_error;
   logic [ADDR_WIDTH-1:0] r_err_addr;
   logic [ADDR_WIDTH-1:0] r_err_count;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  w_last;
   logic                  w_accept;
   logic                  w_mismatch;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic                  w_busy;
   logic                  w_done;

   // One adder serves both the write data and the verify expectation.
   sm_add_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .i_a   (r_cnt[ADDR_WIDTH-1:DATA_WIDTH]),
      .i_b   (r_cnt[DATA_WIDTH-1:0]),
      .o_sum (w_sum)
   );

   assign w_last     = (r_cnt == '1);
   assign w_accept   = (r_state == IDLE) && bus.start;
   assign w_mismatch = r_exp_valid && (bus.rd_data != r_exp_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_wr_en = 1'b0;
      w_rd_en = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next = FILL;
            end
         end
         FILL: begin
            w_busy  = 1'b1;
            w_wr_en = 1'b1;
            if (w_last) begin
               w_next = r_verify ? VERIFY : DONE;
            end
         end
         VERIFY: begin
            w_busy  = 1'b1;
            w_rd_en = 1'b1;
            if (w_last) begin
               w_next = VDRAIN;
            end
         end
         VDRAIN: begin
            w_busy = 1'b1;
            w_next = DONE;
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_verify    <= 1'b0;
         r_exp_valid <= 1'b0;
         r_exp_data  <= '0;
         r_exp_addr  <= '0;
         r_error     <= 1'b0;
         r_err_addr  <= '0;
         r_err_count <= '0;
      end else begin
         // Read data returns a cycle later, so the expectation trails by one.
         r_exp_valid <= w_rd_en;
         r_exp_data  <= w_sum;
         r_exp_addr  <= r_cnt;
         if (w_accept) begin
            r_cnt       <= '0;
            r_verify    <= bus.verify_en;
            r_error     <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
         end else begin
            if (w_wr_en || w_rd_en) begin
               r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
            if (w_mismatch) begin
               r_error <= 1'b1;
               if (!r_error) begin
                  r_err_addr <= r_exp_addr;
               end
               if (r_err_count != '1) begin
                  r_err_count <= r_err_count + ADDR_WIDTH'(1);
               end
            end
         end
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.error     = r_error;
   assign bus.err_addr  = r_err_addr;
   assign bus.err_count = r_err_count;
   assign bus.wr_en     = w_wr_en;
   assign bus.wr_addr   = w_wr_en ? r_cnt : '0;
   assign bus.wr_data   = w_wr_en ? w_sum : '0;
   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr   = w_rd_en ? r_cnt : '0;

endmodule : sm_adder_table_loader
`default_nettype wire
